alu_issue_ctrl: RTL and testbench

Sequential front-end that sits directly upstream of the 8-bit signed ALU and also captures that ALU's result. It buffers incoming operand/command packets in a small FIFO and issues them one at a time on the ALU's a/b/command/oe inputs. It samples the ALU's tri-stated 16-bit result and presents it downstream with a valid/ready handshake and a divide-by-zero flag.

---
 rtl/alu_issue_ctrl.sv | 96 +++++++++
 tb/tb_alu_issue_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered issue front-end for an 8-bit signed ALU, capturing its
// tri-stated result and presenting it downstream with a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int CMD_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [CMD_W-1:0]         in_cmd,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [CMD_W-1:0]         alu_cmd,
  output logic                     alu_oe,
  input  logic [RES_W-1:0]         alu_d,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic [CMD_W-1:0]         res_cmd,
  output logic                     res_divz,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CMD_W-1:0] DIV = CMD_W'(5);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];
  logic [CMD_W-1:0]  r_mem_cmd [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic              w_push, w_pop, w_load;
  assign in_ready = fifo_count != (AW+1)'(DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_load   = r_state == IDLE && fifo_count != '0;
  assign w_pop    = r_state == ISSUE;
  assign alu_oe   = r_state == ISSUE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_load ? ISSUE : IDLE;
      ISSUE:   w_next = HOLD;
      HOLD:    w_next = res_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk)
    if (w_push) begin
      r_mem_a[r_wptr]   <= in_a;
      r_mem_b[r_wptr]   <= in_b;
      r_mem_cmd[r_wptr] <= in_cmd;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // alu_d is sampled only on the edge leaving ISSUE, when the ALU is driving it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cmd   <= '0;
      res_divz  <= 1'b0;
    end else begin
      if (w_load) begin
        alu_a   <= r_mem_a[r_rptr];
        alu_b   <= r_mem_b[r_rptr];
        alu_cmd <= r_mem_cmd[r_rptr];
      end
      if (w_pop) begin
        res_data  <= alu_d;
        res_cmd   <= alu_cmd;
        res_divz  <= alu_cmd == DIV && alu_b == '0;
        res_valid <= 1'b1;
      end else if (r_state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a behavioural tri-state ALU on the result bus.
module tb_alu_issue_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, res_ready = 1;
  logic        in_ready, alu_oe, res_valid, res_divz;
  logic [7:0]  in_a = 0, in_b = 0, alu_a, alu_b;
  logic [3:0]  in_cmd = 0, alu_cmd, res_cmd;
  logic [15:0] res_data, w_res;
  logic [2:0]  fifo_count;
  wire  [15:0] alu_d;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_d(alu_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cmd(res_cmd), .res_divz(res_divz), .fifo_count(fifo_count)
  );

  // ALU: 0000 ADD, 0010 SUB, 0100 MUL, 0101 DIV (divide by zero gives all ones)
  always_comb begin
    logic signed [15:0] sa, sb;
    sa = {{8{alu_a[7]}}, alu_a};
    sb = {{8{alu_b[7]}}, alu_b};
    w_res = 16'h0000;
    case (alu_cmd)
      4'b0000: w_res = sa + sb;
      4'b0010: w_res = sa - sb;
      4'b0100: w_res = sa * sb;
      4'b0101: w_res = (sb == 0) ? 16'hFFFF : sa / sb;
      default: w_res = 16'h0000;
    endcase
  end
  assign alu_d = alu_oe ? w_res : 16'bz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    in_valid = 1; in_a = a; in_b = b; in_cmd = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_res(input string tag, input logic [15:0] d, input logic [3:0] c,
                          input logic z);
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(res_valid), 1);
    chk({tag, "_data"}, 32'(res_data), 32'(d));
    chk({tag, "_cmd"}, 32'(res_cmd), 32'(c));
    chk({tag, "_divz"}, 32'(res_divz), 32'(z));
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_oe", 32'(alu_oe), 0);
    chk("rst_data", 32'(res_data), 0);
    rst_n = 1;
    @(negedge clk);
    // ADD with latency and single-cycle oe pulse
    push(8'd5, 8'd3, 4'b0000);
    chk("add_count", 32'(fifo_count), 1);
    chk("add_oe_pre", 32'(alu_oe), 0);
    @(negedge clk);
    chk("add_oe_issue", 32'(alu_oe), 1);
    chk("add_alu_a", 32'(alu_a), 5);
    chk("add_rv_issue", 32'(res_valid), 0);
    @(negedge clk);
    chk("add_rv_lat", 32'(res_valid), 1);
    chk("add_oe_hold", 32'(alu_oe), 0);
    wait_res("add", 16'h0008, 4'b0000, 0);
    chk("add_rv_clr", 32'(res_valid), 0);
    // SUB then MUL back-to-back, results in push order
    in_valid = 1; in_a = 8'd3; in_b = 8'd5; in_cmd = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    push(8'hFE, 8'd7, 4'b0100);
    wait_res("sub", 16'hFFFE, 4'b0010, 0);
    wait_res("mul", 16'hFFF2, 4'b0100, 0);
    // DIV by zero then a normal DIV
    push(8'd7, 8'd0, 4'b0101);
    push(8'd8, 8'd2, 4'b0101);
    wait_res("divz", 16'hFFFF, 4'b0101, 1);
    wait_res("div", 16'h0004, 4'b0101, 0);
    repeat (3) @(negedge clk);
    // Park a result in HOLD, then fill the FIFO under backpressure
    res_ready = 0;
    push(8'd1, 8'd1, 4'b0000);
    repeat (3) @(negedge clk);
    chk("hold_rv", 32'(res_valid), 1);
    chk("hold_data", 32'(res_data), 32'h0002);
    push(8'd10, 8'd1, 4'b0000);
    push(8'd1, 8'd2, 4'b0010);
    push(8'd3, 8'd3, 4'b0100);
    chk("fill_ready3", 32'(in_ready), 1);
    push(8'd100, 8'd100, 4'b0000);
    chk("full_ready", 32'(in_ready), 0);
    push(8'd50, 8'd50, 4'b0000);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_data_stable", 32'(res_data), 32'h0002);
    chk("full_rv", 32'(res_valid), 1);
    // Retire one result; in_ready returns only after the pop edge
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("rel_rv", 32'(res_valid), 0);
    chk("rel_count", 32'(fifo_count), 4);
    chk("rel_ready_idle", 32'(in_ready), 0);
    @(negedge clk);
    chk("rel_oe", 32'(alu_oe), 1);
    chk("rel_ready_issue", 32'(in_ready), 0);
    @(negedge clk);
    chk("rel_ready_pop", 32'(in_ready), 1);
    chk("rel_count_pop", 32'(fifo_count), 3);
    res_ready = 1;
    wait_res("q0", 16'h000B, 4'b0000, 0);
    wait_res("q1", 16'hFFFF, 4'b0010, 0);
    wait_res("q2", 16'h0009, 4'b0100, 0);
    wait_res("q3", 16'h00C8, 4'b0000, 0);
    repeat (6) @(negedge clk);
    chk("drain_rv", 32'(res_valid), 0);
    chk("drain_count", 32'(fifo_count), 0);
    // Reset during ISSUE aborts everything
    push(8'd1, 8'd2, 4'b0000);
    push(8'd4, 8'd4, 4'b0000);
    chk("pre_rst_oe", 32'(alu_oe), 1);
    chk("pre_rst_count", 32'(fifo_count), 2);
    rst_n = 0;
    #1;
    chk("rst_mid_oe", 32'(alu_oe), 0);
    chk("rst_mid_rv", 32'(res_valid), 0);
    chk("rst_mid_count", 32'(fifo_count), 0);
    chk("rst_mid_ready", 32'(in_ready), 1);
    chk("rst_mid_alu_a", 32'(alu_a), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_rv", 32'(res_valid), 0);
      chk("post_rst_oe", 32'(alu_oe), 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
